// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory port bundle for the MEM-stage
// load/store unit. The unit uses the slave view; the pipeline/memory side
// uses the master view.
interface mem_access_unit_if;
  // Pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Word-aligned data-memory port
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // Pipeline response
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wstrb, mem_wdata,
           resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wstrb, mem_wdata,
           resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator. Accepts one request at a time, splits
// word-crossing accesses into two aligned beats, merges and extends load
// data, and returns one registered response per request.
module mem_access_unit #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC1  = 3'd1,
    S_ACC2  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      r_state;

  // Latched request attributes
  logic        r_write;
  logic [2:0]  r_func3;
  logic [1:0]  r_off;
  logic [31:0] r_word0;
  logic [3:0]  r_strb1;     // upper half of the 8-lane window; nonzero means split
  logic [31:0] r_wdata1;    // store data pre-shifted for the second word
  logic [31:0] r_rdata0;    // first word of a split load

  // Registered outputs
  logic [31:0] r_mem_addr;
  logic        r_mem_re;
  logic        r_mem_we;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  // Request decode (only meaningful in IDLE)
  logic        w_legal;
  logic [7:0]  w_req_lanes;
  logic        w_req_split;
  logic        w_req_err;
  logic [31:0] w_req_word0;
  logic [4:0]  w_req_shift;
  logic [31:0] w_req_wdata0;
  logic [31:0] w_req_wdata1;

  // Load merge path
  logic        w_split;
  logic [31:0] w_word1;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic [31:0] w_merged;
  logic [31:0] w_load_ext;

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_re     = r_mem_re;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wstrb  = r_mem_wstrb;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;

  assign w_split = |r_strb1;
  assign w_word1 = r_word0 + 32'd4;   // wraps 0xFFFFFFFC -> 0x00000000

  // Decode legality, byte-lane window and split need of the incoming request
  always_comb begin
    logic [7:0] w_base;
    if (bus.req_write)
      w_legal = bus.req_func3 inside {3'd0, 3'd1, 3'd2};
    else
      w_legal = bus.req_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    case (bus.req_func3[1:0])
      2'd0:    w_base = 8'h01;
      2'd1:    w_base = 8'h03;
      default: w_base = 8'h0F;
    endcase
    w_req_lanes  = w_base << bus.req_addr[1:0];
    w_req_split  = |w_req_lanes[7:4];
    w_req_err    = !w_legal || (w_req_split && !MISALIGN_EN);
    w_req_word0  = {bus.req_addr[31:2], 2'b00};
    w_req_shift  = {bus.req_addr[1:0], 3'b000};
    w_req_wdata0 = bus.req_wdata << w_req_shift;
    // Second word gets the bytes that spilled past lane 3; shift of 32 gives 0
    w_req_wdata1 = bus.req_wdata >> (6'd32 - {1'b0, w_req_shift});
  end

  // Merge the captured word(s), align to offset and extend by load type
  always_comb begin
    w_hi     = w_split ? bus.mem_rdata : 32'd0;
    w_lo     = w_split ? r_rdata0      : bus.mem_rdata;
    w_merged = 32'({w_hi, w_lo} >> {r_off, 3'b000});
    case (r_func3)
      3'd0:    w_load_ext = {{24{w_merged[7]}},  w_merged[7:0]};
      3'd1:    w_load_ext = {{16{w_merged[15]}}, w_merged[15:0]};
      3'd4:    w_load_ext = {24'd0, w_merged[7:0]};
      3'd5:    w_load_ext = {16'd0, w_merged[15:0]};
      default: w_load_ext = w_merged;
    endcase
  end

  // Access sequencer: state, latched request and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_func3      <= 3'd0;
      r_off        <= 2'd0;
      r_word0      <= 32'd0;
      r_strb1      <= 4'd0;
      r_wdata1     <= 32'd0;
      r_rdata0     <= 32'd0;
      r_mem_addr   <= 32'd0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_wstrb  <= 4'd0;
      r_mem_wdata  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_write  <= bus.req_write;
            r_func3  <= bus.req_func3;
            r_off    <= bus.req_addr[1:0];
            r_word0  <= w_req_word0;
            r_strb1  <= w_req_lanes[7:4];
            r_wdata1 <= w_req_wdata1;
            if (w_req_err) begin
              // Illegal or rejected request: answer next cycle, touch no memory
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'd0;
            end else begin
              r_state     <= S_ACC1;
              r_mem_addr  <= w_req_word0;
              r_mem_re    <= !bus.req_write;
              r_mem_we    <= bus.req_write;
              r_mem_wstrb <= bus.req_write ? w_req_lanes[3:0] : 4'd0;
              r_mem_wdata <= w_req_wdata0;
            end
          end
        end
        S_ACC1: begin
          if (w_split) begin
            r_state     <= S_ACC2;
            r_mem_addr  <= w_word1;
            r_mem_re    <= !r_write;
            r_mem_we    <= r_write;
            r_mem_wstrb <= r_write ? r_strb1 : 4'd0;
            r_mem_wdata <= r_wdata1;
          end else begin
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'd0;
            if (r_write) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_data  <= 32'd0;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_ACC2: begin
          // Read data of the first beat arrives now
          r_rdata0    <= bus.mem_rdata;
          r_mem_re    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_wstrb <= 4'd0;
          if (r_write) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= 32'd0;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_data  <= w_load_ext;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected memory beats and responses
// are queued when a request is driven and checked as the unit produces them.
module tb_mem_access_unit;

  localparam logic [2:0] F_B  = 3'd0;
  localparam logic [2:0] F_H  = 3'd1;
  localparam logic [2:0] F_W  = 3'd2;
  localparam logic [2:0] F_BU = 3'd4;
  localparam logic [2:0] F_HU = 3'd5;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          t;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   dut2_acc = 0;

  resp_t resp_q[$];
  acc_t  acc_q[$];

  logic [31:0] mem [128];

  mem_access_unit_if bus ();
  mem_access_unit_if bus2 ();

  mem_access_unit #(.MISALIGN_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mem_access_unit #(.MISALIGN_EN(1'b0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  assign bus2.mem_rdata = 32'hCAFEF00D;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: preload while reset is low, byte-lane writes, 1-cycle read
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
      mem[7'h00] <= 32'h12345678;
      mem[7'h40] <= 32'h44332211;
      mem[7'h41] <= 32'h88776655;
      mem[7'h7F] <= 32'hDEADBEEF;
      bus.mem_rdata <= 32'd0;
    end else begin
      if (bus.mem_we)
        for (int i = 0; i < 4; i++)
          if (bus.mem_wstrb[i]) mem[bus.mem_addr[8:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[8:2]];
    end
  end

  always @(negedge clk) if (reset && (bus2.mem_re || bus2.mem_we)) dut2_acc <= dut2_acc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Monitor: compare memory beats and responses against the queued expectations
  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_re || bus.mem_we) begin
        acc_t a;
        check("re_we_excl", 32'(bus.mem_re & bus.mem_we), 32'd0);
        if (acc_q.size() == 0) begin
          check("acc_expected", 32'(acc_q.size()), 32'd1);
        end else begin
          a = acc_q.pop_front();
          $display("access we=%0d addr=0x%08h strb=%b wdata=0x%08h", bus.mem_we,
                   bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
          check("acc_we", 32'(bus.mem_we), 32'(a.we));
          check("acc_addr", bus.mem_addr, a.addr);
          check("acc_strb", 32'(bus.mem_wstrb), 32'(a.strb));
          if (a.we) check("acc_wdata", bus.mem_wdata, a.wdata);
        end
      end
      if (bus.resp_valid) begin
        resp_t r;
        if (resp_q.size() == 0) begin
          check("resp_expected", 32'(resp_q.size()), 32'd1);
        end else begin
          r = resp_q.pop_front();
          $display("response data=0x%08h err=%0d latency=%0d", bus.resp_data, bus.resp_err,
                   cyc - r.t);
          check("resp_data", bus.resp_data, r.data);
          check("resp_err", 32'(bus.resp_err), 32'(r.err));
          check("resp_lat", 32'(cyc - r.t), 32'(r.lat));
        end
      end
    end
  end

  task automatic exp_rd(input logic [31:0] addr);
    acc_q.push_back('{we: 1'b0, addr: addr, strb: 4'd0, wdata: 32'd0});
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    acc_q.push_back('{we: 1'b1, addr: addr, strb: strb, wdata: wd});
  endtask

  // Drive one request, queue its expected response and wait (bounded) for it
  task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_data,
                      input logic exp_err, input int lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    check("req_ready", 32'(bus.req_ready), 32'd1);
    resp_q.push_back('{data: exp_data, err: exp_err, t: cyc, lat: lat});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_func3 = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (int i = 0; i < 20 && resp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (resp_q.size() != 0) begin
      check("resp_timeout", 32'(resp_q.size()), 32'd0);
      resp_q.delete();
    end
    if (acc_q.size() != 0) begin
      check("acc_missing", 32'(acc_q.size()), 32'd0);
      acc_q.delete();
    end
  endtask

  // Request on the non-splitting instance; its memory always returns 0xCAFEF00D
  task automatic send2(input logic [31:0] addr, input logic [31:0] exp_data,
                       input logic exp_err, input int lat, input int exp_acc);
    int t0;
    int base;
    bit seen;
    @(negedge clk);
    base = dut2_acc;
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b0;
    bus2.req_func3 = F_W;
    bus2.req_addr  = addr;
    bus2.req_wdata = 32'd0;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus2.resp_valid) begin
        seen = 1'b1;
        $display("dut2 response data=0x%08h err=%0d latency=%0d", bus2.resp_data,
                 bus2.resp_err, cyc - t0);
        check("d2_resp_err", 32'(bus2.resp_err), 32'(exp_err));
        check("d2_resp_data", bus2.resp_data, exp_data);
        check("d2_resp_lat", 32'(cyc - t0), 32'(lat));
      end
    end
    check("d2_resp_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #1;
    check("d2_accesses", 32'(dut2_acc - base), 32'(exp_acc));
  endtask

  task automatic check_reset_outputs(input string who);
    check({who, "_mem_addr"},   bus.mem_addr, 32'd0);
    check({who, "_mem_re"},     32'(bus.mem_re), 32'd0);
    check({who, "_mem_we"},     32'(bus.mem_we), 32'd0);
    check({who, "_mem_wstrb"},  32'(bus.mem_wstrb), 32'd0);
    check({who, "_mem_wdata"},  bus.mem_wdata, 32'd0);
    check({who, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({who, "_resp_data"},  bus.resp_data, 32'd0);
    check({who, "_resp_err"},   32'(bus.resp_err), 32'd0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_func3  = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus2.req_valid = 1'b0;
    bus2.req_write = 1'b0;
    bus2.req_func3 = 3'd0;
    bus2.req_addr  = 32'd0;
    bus2.req_wdata = 32'd0;

    // Power-on reset
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Aligned and sub-word loads
    exp_rd(32'h100); send(1'b0, F_W,  32'h100, 32'd0, 32'h44332211, 1'b0, 3);
    exp_rd(32'h100); send(1'b0, F_B,  32'h103, 32'd0, 32'h00000044, 1'b0, 3);
    exp_rd(32'h104); send(1'b0, F_B,  32'h107, 32'd0, 32'hFFFFFF88, 1'b0, 3);
    exp_rd(32'h104); send(1'b0, F_BU, 32'h107, 32'd0, 32'h00000088, 1'b0, 3);
    exp_rd(32'h104); send(1'b0, F_H,  32'h106, 32'd0, 32'hFFFF8877, 1'b0, 3);
    exp_rd(32'h104); send(1'b0, F_HU, 32'h106, 32'd0, 32'h00008877, 1'b0, 3);

    // Split loads, including the address wrap
    exp_rd(32'h100); exp_rd(32'h104);
    send(1'b0, F_W, 32'h102, 32'd0, 32'h66554433, 1'b0, 4);
    exp_rd(32'h100); exp_rd(32'h104);
    send(1'b0, F_H, 32'h103, 32'd0, 32'h00005544, 1'b0, 4);
    exp_rd(32'hFFFFFFFC); exp_rd(32'h00000000);
    send(1'b0, F_W, 32'hFFFFFFFE, 32'd0, 32'h5678DEAD, 1'b0, 4);

    // Reset during the second beat of a split load
    exp_rd(32'h100);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_func3 = F_W;
    bus.req_addr  = 32'h102;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 check("mid_in_acc2_re", 32'(bus.mem_re), 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("mid_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_acc_left", 32'(acc_q.size()), 32'd0);
    acc_q.delete();
    exp_rd(32'h104); send(1'b0, F_W, 32'h104, 32'd0, 32'h88776655, 1'b0, 3);

    // Split store and readback
    exp_wr(32'h100, 4'b1110, 32'hBBCCDD00); exp_wr(32'h104, 4'b0001, 32'h000000AA);
    send(1'b1, F_W, 32'h101, 32'hAABBCCDD, 32'd0, 1'b0, 3);
    exp_rd(32'h100); send(1'b0, F_W, 32'h100, 32'd0, 32'hBBCCDD11, 1'b0, 3);
    exp_rd(32'h104); send(1'b0, F_W, 32'h104, 32'd0, 32'h887766AA, 1'b0, 3);

    // Unsplit byte/half stores with junk in upper store-data bits
    exp_wr(32'h100, 4'b0100, 32'hFF5A0000);
    send(1'b1, F_B, 32'h102, 32'hFFFFFF5A, 32'd0, 1'b0, 2);
    exp_rd(32'h100); send(1'b0, F_W, 32'h100, 32'd0, 32'hBB5ADD11, 1'b0, 3);
    exp_wr(32'h104, 4'b1100, 32'h56780000);
    send(1'b1, F_H, 32'h106, 32'h12345678, 32'd0, 1'b0, 2);
    exp_rd(32'h104); send(1'b0, F_W, 32'h104, 32'd0, 32'h567866AA, 1'b0, 3);

    // Split halfword store then split halfword load of the same bytes
    exp_wr(32'h104, 4'b1000, 32'hEF000000); exp_wr(32'h108, 4'b0001, 32'h000000BE);
    send(1'b1, F_H, 32'h107, 32'h0000BEEF, 32'd0, 1'b0, 3);
    exp_rd(32'h104); exp_rd(32'h108);
    send(1'b0, F_HU, 32'h107, 32'd0, 32'h0000BEEF, 1'b0, 4);
    exp_rd(32'h104); exp_rd(32'h108);
    send(1'b0, F_H, 32'h107, 32'd0, 32'hFFFFBEEF, 1'b0, 4);

    // Illegal func3: answered next cycle, no memory access
    send(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 1'b1, 1);
    send(1'b0, 3'd7, 32'h104, 32'd0, 32'd0, 1'b1, 1);
    send(1'b1, 3'd4, 32'h100, 32'h11111111, 32'd0, 1'b1, 1);
    send(1'b1, 3'd3, 32'h104, 32'h22222222, 32'd0, 1'b1, 1);
    exp_rd(32'h100); send(1'b0, F_W, 32'h100, 32'd0, 32'hBB5ADD11, 1'b0, 3);

    // Misalignment rejected when splitting is disabled; aligned still works
    send2(32'h102, 32'd0, 1'b1, 1, 0);
    send2(32'h100, 32'hCAFEF00D, 1'b0, 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
